// File: rtl/uio_arb_pkg.sv
// rtl/uio_arb_pkg.sv - shared state type, defaults and index-width helper for uio_bus_arbiter
package uio_arb_pkg;

   typedef enum logic [1:0] {IDLE, GRANT, TURN} arb_state_t;

   localparam int DEF_N_REQ    = 4;
   localparam int DEF_WIDTH    = 8;
   localparam int DEF_MAX_HOLD = 16;
   localparam int DEF_TURN_CYC = 1;
   localparam int IDX_W        = $clog2(DEF_N_REQ);

   // Width of an index/counter able to hold 0..n-1, never narrower than one bit.
   function automatic int idx_w(input int n);
      return (n < 2) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/rr_pick.sv
// rtl/rr_pick.sv - combinational round-robin first-set search starting at a given index
module rr_pick
   import uio_arb_pkg::*;
#(
   parameter int N  = DEF_N_REQ,
   parameter int IW = idx_w(DEF_N_REQ)
) (
   input  logic [N-1:0]  req,
   input  logic [IW-1:0] start,
   output logic [IW-1:0] sel,
   output logic          valid
);

   logic [IW-1:0] idx;

   // Walk from farthest to nearest so the closest set bit to start wins.
   always_comb begin
      sel   = start;
      idx   = start;
      valid = |req;
      for (int k = N - 1; k >= 0; k--) begin
         idx = IW'((int'(start) + k) % N);
         if (req[idx]) begin
            sel = idx;
         end
      end
   end

endmodule

// File: rtl/uio_bus_arbiter.sv
// rtl/uio_bus_arbiter.sv - round-robin owner of the uio pad bank with turnaround gap and hold limit
// Optional UIO_ARB_LOCK_EN adds a per-requester lock input that suppresses hold-time preemption.
module uio_bus_arbiter
   import uio_arb_pkg::*;
#(
   parameter int N_REQ    = DEF_N_REQ,
   parameter int WIDTH    = DEF_WIDTH,
   parameter int MAX_HOLD = DEF_MAX_HOLD,
   parameter int TURN_CYC = DEF_TURN_CYC
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    ena,
   input  logic [N_REQ-1:0]        req,
`ifdef UIO_ARB_LOCK_EN
   input  logic [N_REQ-1:0]        lock,
`endif
   input  logic [N_REQ*WIDTH-1:0]  req_out,
   input  logic [N_REQ*WIDTH-1:0]  req_oe,
   output logic [N_REQ-1:0]        grant,
   output logic [idx_w(N_REQ)-1:0] owner,
   output logic                    busy,
   output logic [WIDTH-1:0]        uio_out,
   output logic [WIDTH-1:0]        uio_oe
);

   localparam int IW = idx_w(N_REQ);
   localparam int HW = idx_w(MAX_HOLD);
   localparam int TW = idx_w(TURN_CYC);
   localparam logic [HW-1:0] HOLD_LAST = HW'(MAX_HOLD - 1);
   localparam logic [TW-1:0] TURN_LAST = TW'(TURN_CYC - 1);
   localparam logic [IW-1:0] OWN_LAST  = IW'(N_REQ - 1);

   arb_state_t        state, state_nxt;
   logic [IW-1:0]     owner_nxt;
   logic [HW-1:0]     hold_cnt, hold_nxt;
   logic [TW-1:0]     turn_cnt, turn_nxt;
   logic [WIDTH-1:0]  out_nxt, oe_nxt;
   logic [IW-1:0]     start, pick_sel;
   logic              pick_valid;
   logic [N_REQ-1:0]  owner_mask;
   logic              others_pending, preempt_ok, preempt, release_now;

   assign start          = (owner == OWN_LAST) ? '0 : owner + IW'(1);
   assign owner_mask     = N_REQ'(1) << owner;
   assign others_pending = |(req & ~owner_mask);
`ifdef UIO_ARB_LOCK_EN
   assign preempt_ok     = ~lock[owner];
`else
   assign preempt_ok     = 1'b1;
`endif
   assign preempt        = (hold_cnt == HOLD_LAST) && others_pending && preempt_ok;
   assign release_now    = !req[owner] || !ena;

   assign grant = (state == GRANT) ? owner_mask : '0;
   assign busy  = (state != IDLE);

   rr_pick #(.N(N_REQ), .IW(IW)) u_pick (
      .req   (req),
      .start (start),
      .sel   (pick_sel),
      .valid (pick_valid)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= IDLE;
         owner    <= OWN_LAST;
         hold_cnt <= '0;
         turn_cnt <= '0;
         uio_out  <= '0;
         uio_oe   <= '0;
      end else begin
         state    <= state_nxt;
         owner    <= owner_nxt;
         hold_cnt <= hold_nxt;
         turn_cnt <= turn_nxt;
         uio_out  <= out_nxt;
         uio_oe   <= oe_nxt;
      end
   end

   // Pads are zero outside GRANT, and also on the edge that leaves GRANT.
   always_comb begin
      state_nxt = state;
      owner_nxt = owner;
      hold_nxt  = hold_cnt;
      turn_nxt  = turn_cnt;
      out_nxt   = '0;
      oe_nxt    = '0;
      case (state)
         IDLE: begin
            if (ena && pick_valid) begin
               state_nxt = GRANT;
               owner_nxt = pick_sel;
               hold_nxt  = '0;
            end
         end
         GRANT: begin
            if (release_now || preempt) begin
               state_nxt = TURN;
               turn_nxt  = '0;
            end else begin
               out_nxt = req_out[int'(owner)*WIDTH +: WIDTH];
               oe_nxt  = req_oe[int'(owner)*WIDTH +: WIDTH];
               if (hold_cnt != HOLD_LAST) begin
                  hold_nxt = hold_cnt + HW'(1);
               end
            end
         end
         TURN: begin
            if (turn_cnt == TURN_LAST) begin
               state_nxt = IDLE;
            end else begin
               turn_nxt = turn_cnt + TW'(1);
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

endmodule

// File: tb/tb_uio_bus_arbiter.sv
// tb/tb_uio_bus_arbiter.sv - self-checking bench for uio_bus_arbiter (defaults N_REQ=4, MAX_HOLD=16, TURN_CYC=1)
module tb_uio_bus_arbiter;

   localparam int N        = 4;
   localparam int W        = 8;
   localparam int MAX_HOLD = 16;
   localparam int TURN_CYC = 1;

   logic           clk = 1'b0;
   logic           rst_n;
   logic           ena;
   logic [N-1:0]   req;
`ifdef UIO_ARB_LOCK_EN
   logic [N-1:0]   lock;
`endif
   logic [N*W-1:0] req_out;
   logic [N*W-1:0] req_oe;
   logic [N-1:0]   grant;
   logic [1:0]     owner;
   logic           busy;
   logic [W-1:0]   uio_out;
   logic [W-1:0]   uio_oe;

   int n_cmp = 0;
   int n_bad = 0;

   uio_bus_arbiter dut (
      .clk     (clk),
      .rst_n   (rst_n),
      .ena     (ena),
      .req     (req),
`ifdef UIO_ARB_LOCK_EN
      .lock    (lock),
`endif
      .req_out (req_out),
      .req_oe  (req_oe),
      .grant   (grant),
      .owner   (owner),
      .busy    (busy),
      .uio_out (uio_out),
      .uio_oe  (uio_oe)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic       rst_n;
      logic       ena;
      logic [3:0] req;
      logic [3:0] g;
      logic [1:0] o;
      logic       b;
      logic [7:0] d;
      logic [7:0] e;
   } vec_t;

   vec_t tbl[14];

   // Reference: who holds the bus, for how long, and how many turnaround cycles remain.
   int         m_own, m_last, m_ten, m_gap;
   logic [7:0] e_out, e_oe;
   int         k, r, o;

   task automatic tick();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic check(input string name, input logic [3:0] g, input logic [1:0] ow,
                        input logic b, input logic [7:0] d, input logic [7:0] e);
      n_cmp++;
      if (grant !== g || owner !== ow || busy !== b || uio_out !== d || uio_oe !== e) begin
         n_bad++;
         $display("FAIL %s t=%0t: got grant=%b owner=%0d busy=%b out=%h oe=%h, want grant=%b owner=%0d busy=%b out=%h oe=%h",
                  name, $time, grant, owner, busy, uio_out, uio_oe, g, ow, b, d, e);
      end
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
   endtask

   task automatic model_reset();
      m_own  = -1;
      m_last = N - 1;
      m_ten  = 0;
      m_gap  = 0;
      e_out  = '0;
      e_oe   = '0;
   endtask

   task automatic model_step();
      int         prev;
      logic [3:0] others;
      prev = m_own;
      if (m_own >= 0) begin
         others = req & ~(4'(1 << m_own));
         if (!req[m_own] || !ena || (m_ten >= MAX_HOLD - 1 && others != 0)) begin
            m_own = -1;
            m_gap = TURN_CYC;
         end else begin
            m_ten++;
         end
      end else if (m_gap > 0) begin
         m_gap--;
      end else if (ena && req != 0) begin
         for (int i = 1; i <= N; i++) begin
            if (req[(m_last + i) % N]) begin
               m_own  = (m_last + i) % N;
               m_last = m_own;
               m_ten  = 0;
               break;
            end
         end
      end
      if (prev >= 0 && m_own == prev) begin
         e_out = req_out[prev*W +: W];
         e_oe  = req_oe[prev*W +: W];
      end else begin
         e_out = '0;
         e_oe  = '0;
      end
   endtask

   initial begin
      tbl[0]  = '{1'b1, 1'b1, 4'b0101, 4'b0001, 2'd0, 1'b1, 8'h00, 8'h00};
      tbl[1]  = '{1'b1, 1'b1, 4'b0101, 4'b0001, 2'd0, 1'b1, 8'hA5, 8'hFF};
      tbl[2]  = '{1'b1, 1'b1, 4'b0101, 4'b0001, 2'd0, 1'b1, 8'hA5, 8'hFF};
      tbl[3]  = '{1'b1, 1'b1, 4'b0101, 4'b0001, 2'd0, 1'b1, 8'hA5, 8'hFF};
      tbl[4]  = '{1'b1, 1'b1, 4'b0101, 4'b0001, 2'd0, 1'b1, 8'hA5, 8'hFF};
      tbl[5]  = '{1'b1, 1'b1, 4'b0100, 4'b0000, 2'd0, 1'b1, 8'h00, 8'h00};
      tbl[6]  = '{1'b1, 1'b1, 4'b0100, 4'b0000, 2'd0, 1'b0, 8'h00, 8'h00};
      tbl[7]  = '{1'b1, 1'b1, 4'b0100, 4'b0100, 2'd2, 1'b1, 8'h00, 8'h00};
      tbl[8]  = '{1'b1, 1'b1, 4'b0100, 4'b0100, 2'd2, 1'b1, 8'h3C, 8'h0F};
      tbl[9]  = '{1'b1, 1'b0, 4'b0100, 4'b0000, 2'd2, 1'b1, 8'h00, 8'h00};
      tbl[10] = '{1'b1, 1'b0, 4'b0100, 4'b0000, 2'd2, 1'b0, 8'h00, 8'h00};
      tbl[11] = '{1'b1, 1'b0, 4'b0100, 4'b0000, 2'd2, 1'b0, 8'h00, 8'h00};
      tbl[12] = '{1'b1, 1'b1, 4'b0100, 4'b0100, 2'd2, 1'b1, 8'h00, 8'h00};
      tbl[13] = '{1'b1, 1'b1, 4'b0100, 4'b0100, 2'd2, 1'b1, 8'h3C, 8'h0F};

      rst_n   = 1'b0;
      ena     = 1'b1;
      req     = 4'b0101;
`ifdef UIO_ARB_LOCK_EN
      lock    = '0;
`endif
      req_out = {8'h5A, 8'h3C, 8'h11, 8'hA5};
      req_oe  = {8'hAA, 8'h0F, 8'hF0, 8'hFF};
      tick();
      tick();
      check("reset", 4'b0000, 2'd3, 1'b0, 8'h00, 8'h00);

      for (int i = 0; i < 14; i++) begin
         rst_n = tbl[i].rst_n;
         ena   = tbl[i].ena;
         req   = tbl[i].req;
         tick();
         check($sformatf("vec%0d", i), tbl[i].g, tbl[i].o, tbl[i].b, tbl[i].d, tbl[i].e);
      end

      // All four requesting: 16-cycle tenures, 2 grant-free cycles, 3 oe-free cycles.
      req = 4'b1111;
      ena = 1'b1;
      do_reset();
      for (int c = 1; c <= 90; c++) begin
         k = (c - 1) / 18;
         r = (c - 1) % 18;
         o = k % 4;
         tick();
         check("preempt", (r < 16) ? 4'(1 << o) : 4'b0000, 2'(o), (r < 17),
               (r >= 1 && r < 16) ? req_out[o*W +: W] : 8'h00,
               (r >= 1 && r < 16) ? req_oe[o*W +: W] : 8'h00);
      end

      req = 4'b0010;
      do_reset();
      for (int c = 1; c <= 100; c++) begin
         tick();
         check("sole", 4'b0010, 2'd1, 1'b1, (c >= 2) ? 8'h11 : 8'h00, (c >= 2) ? 8'hF0 : 8'h00);
      end

      req = 4'b0001;
      do_reset();
      tick();
      tick();
      tick();
      check("pre_arst", 4'b0001, 2'd0, 1'b1, 8'hA5, 8'hFF);
      #2 rst_n = 1'b0;
      #1 check("arst", 4'b0000, 2'd3, 1'b0, 8'h00, 8'h00);
      tick();

`ifdef UIO_ARB_LOCK_EN
      req  = 4'b1111;
      lock = 4'b1111;
      do_reset();
      for (int c = 1; c <= 40; c++) begin
         tick();
         check("lock", 4'b0001, 2'd0, 1'b1, (c >= 2) ? 8'hA5 : 8'h00, (c >= 2) ? 8'hFF : 8'h00);
      end
      lock = '0;
`endif

      req = 4'b0000;
      do_reset();
      model_reset();
      for (int c = 0; c < 1500; c++) begin
         if ($urandom_range(0, 9) == 0) req = 4'($urandom);
         ena     = ($urandom_range(0, 31) != 0);
         req_out = $urandom;
         req_oe  = $urandom;
         model_step();
         tick();
         check("rand", (m_own >= 0) ? 4'(1 << m_own) : 4'b0000, 2'(m_last),
               (m_own >= 0) || (m_gap > 0), e_out, e_oe);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
